memory_access_stage: RTL

//  MEM stage directly downstream of EX. Takes EX's alu_data (address/result), memory_data (store data) and control_out.

---
 rtl/memory_access_stage_pkg.sv | 29 ++
 rtl/memory_access_stage_load_store_align.sv | 52 +++++
 rtl/memory_access_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM states, funct3 encodings
// and the control bundle that travels EX -> MEM -> WB.
package memory_access_stage_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_WAIT
  } mem_state_t;

  // Loads and stores share encodings; the access size lives in funct3[1:0].
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    logic       reg_write;
    logic       mem_to_reg;
  } control_type;

endpackage

// File: rtl/memory_access_stage_load_store_align.sv
// Combinational lane logic: byte enables, store-data replication,
// load lane extraction with sign/zero extension, and alignment check.
module load_store_align
  import memory_access_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] lane;

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    misaligned = 1'b0;
    lane       = load_word >> {addr_lo, 3'b000};
    load_data  = lane;

    case (funct3[1:0])
      F3_SB[1:0]: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_SH[1:0]: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = (addr_lo != 2'b00);
      end
    endcase

    case (funct3)
      F3_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  load_data = {24'h0, lane[7:0]};
      F3_LHU:  load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues data-memory accesses over req/gnt/rvalid,
// stalls upstream while an access is in flight, and registers MEM/WB outputs.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  control_type control_in,
  input  logic [31:0] alu_data,
  input  logic [31:0] memory_data,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output control_type wb_control,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic [31:0] mem_forward_data,
  output logic        misaligned,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t  state;
  logic [CNT_W-1:0] wait_cnt;
  control_type acc_ctrl;
  logic [31:0] acc_addr;
  logic [31:0] acc_data;
  logic [4:0]  acc_rd;

  logic        busy, mem_op, accept, done, expire;
  logic [2:0]  sel_funct3;
  logic [1:0]  sel_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;
  logic        al_misaligned;
  control_type killed_in, killed_acc;

  // In IDLE the aligner judges the incoming op; once busy it serves the latched one.
  assign sel_funct3  = busy ? acc_ctrl.funct3 : control_in.funct3;
  assign sel_addr_lo = busy ? acc_addr[1:0]   : alu_data[1:0];

  load_store_align u_align (
    .funct3     (sel_funct3),
    .addr_lo    (sel_addr_lo),
    .store_data (acc_data),
    .load_word  (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned)
  );

  always_comb begin
    busy     = (state != MEM_IDLE);
    mem_op   = control_in.mem_read | control_in.mem_write;
    accept   = !busy && ex_valid && mem_op && !al_misaligned;
    done     = ((state == MEM_REQ) && dmem_gnt && dmem_rvalid) ||
               ((state == MEM_WAIT) && dmem_rvalid);
    expire   = busy && !done && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // Stall releases in the completion/abort cycle so EX advances on that edge.
    mem_stall = accept || (busy && !done && !expire);

    killed_in            = control_in;
    killed_in.reg_write  = 1'b0;
    killed_acc           = acc_ctrl;
    killed_acc.reg_write = 1'b0;

    dmem_req   = (state == MEM_REQ);
    dmem_we    = dmem_req && acc_ctrl.mem_write;
    dmem_addr  = dmem_req ? {acc_addr[31:2], 2'b00} : 32'h0;
    dmem_be    = dmem_req ? al_be : 4'b0000;
    dmem_wdata = dmem_req ? al_wdata : 32'h0;
  end

  assign mem_forward_data = wb_data;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= MEM_IDLE;
      wait_cnt   <= '0;
      acc_ctrl   <= '0;
      acc_addr   <= '0;
      acc_data   <= '0;
      acc_rd     <= '0;
      wb_valid   <= 1'b0;
      wb_control <= '0;
      wb_data    <= '0;
      wb_rd      <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      wb_control <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;

      case (state)
        MEM_IDLE: begin
          if (ex_valid) begin
            if (!mem_op) begin
              wb_valid   <= 1'b1;
              wb_control <= control_in;
              wb_data    <= alu_data;
              wb_rd      <= rd_in;
            end else if (al_misaligned) begin
              wb_valid   <= 1'b1;
              wb_control <= killed_in;
              wb_data    <= alu_data;
              wb_rd      <= rd_in;
              misaligned <= 1'b1;
            end else begin
              acc_ctrl <= control_in;
              acc_addr <= alu_data;
              acc_data <= memory_data;
              acc_rd   <= rd_in;
              wait_cnt <= '0;
              state    <= MEM_REQ;
            end
          end
        end

        MEM_REQ, MEM_WAIT: begin
          if (done) begin
            wb_valid   <= 1'b1;
            wb_control <= acc_ctrl;
            wb_data    <= acc_ctrl.mem_write ? acc_addr : al_load;
            wb_rd      <= acc_rd;
            state      <= MEM_IDLE;
          end else if (expire) begin
            wb_valid   <= 1'b1;
            wb_control <= killed_acc;
            wb_data    <= acc_addr;
            wb_rd      <= acc_rd;
            bus_err    <= 1'b1;
            state      <= MEM_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if ((state == MEM_REQ) && dmem_gnt) state <= MEM_WAIT;
          end
        end

        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule
